// File: rtl/arb_req_queue.sv
// ---------------------------------------------------------------------------
// arb_req_queue
//
// Per-requester request buffer placed directly in front of one port of the
// two-port round-robin arbiter. Transactions arrive over a valid/ready
// handshake and are held in a DEPTH-entry FIFO. The buffer raises req while
// it holds anything, and on each granted two-cycle arbitration window it
// issues exactly one head entry to the shared downstream port as a one-cycle
// out_valid pulse.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   in_valid  in   upstream transaction valid
//   in_ready  out  buffer can accept this cycle (registered count only)
//   in_data   in   upstream payload, DATA_W bits
//   req       out  to arbiter req_N; buffer holds at least one entry
//   grant     in   from arbiter grant_N; level, held for the 2-cycle window
//   out_valid out  one-cycle pulse, issued transaction valid
//   out_data  out  issued payload, holds its last value between issues
//   count     out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module arb_req_queue #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] FullCount = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] OneCount  = CNT_W'(1);
  localparam logic [PTR_W-1:0] OnePtr    = PTR_W'(1);

  // Storage is deliberately left out of reset; only the pointers and the
  // occupancy counter define which entries are live.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              issued_q, issued_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic push;
  logic issue;

  // Handshake and request are derived from the registered count alone, so a
  // full FIFO refuses a push even in a cycle where it also issues.
  // issued_q blocks a second issue in the second cycle of a grant window;
  // a grant held for two back-to-back windows therefore issues twice.
  always_comb begin
    in_ready = (count_q != FullCount);
    req      = (count_q != '0);
    push     = in_valid && in_ready;
    issue    = grant && (count_q != '0) && !issued_q;
  end

  // Next-state for pointers, occupancy and the issue register. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    issued_d    = issue;
    out_valid_d = issue;
    out_data_d  = out_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + OnePtr;
    end

    if (issue) begin
      rd_ptr_d   = rd_ptr_q + OnePtr;
      out_data_d = mem_q[rd_ptr_q];
    end

    unique case ({push, issue})
      2'b10:   count_d = count_q + OneCount;
      2'b01:   count_d = count_q - OneCount;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      issued_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// ---------------------------------------------------------------------------
// tb_arb_req_queue
//
// Testbench for arb_req_queue. A behavioural model (a plain queue of
// payloads plus the "one issue per window" rule) predicts accepted pushes
// and issued entries; predicted issues go into a scoreboard queue that an
// independent monitor drains whenever the DUT pulses out_valid. The grant
// input comes either from directed stimulus or from a small two-port
// round-robin arbiter model with a randomly requesting second port.
// ---------------------------------------------------------------------------
module tb_arb_req_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              req;
  logic              grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  logic arbOn = 1'b0;
  logic arbGrant = 1'b0;
  logic manGrant = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] modelFifo[$];
  logic [DATA_W-1:0] expQ[$];
  bit                modelIssued = 1'b0;
  bit                modelOv = 1'b0;
  logic [DATA_W-1:0] lastOd = '0;

  assign grant = arbOn ? arbGrant : manGrant;

  arb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted push appends to the queue if it is not
  // full; a grant takes the head if the queue was non-empty and the previous
  // cycle did not already issue. Both decisions use the pre-edge state.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      modelFifo.delete();
      expQ.delete();
      modelIssued = 1'b0;
      modelOv = 1'b0;
    end else begin
      bit pushOk;
      bit issueOk;
      pushOk  = in_valid && (modelFifo.size() < DEPTH);
      issueOk = grant && (modelFifo.size() > 0) && !modelIssued;
      if (issueOk) expQ.push_back(modelFifo.pop_front());
      if (pushOk) modelFifo.push_back(in_data);
      modelIssued = issueOk;
      modelOv = issueOk;
    end
  end

  // Monitor: compares status outputs every cycle and pops the scoreboard
  // whenever the DUT presents an issued transaction.
  always @(negedge clk) begin
    checkOutput("count", 32'(count), 32'(modelFifo.size()));
    checkOutput("req", 32'(req), 32'(modelFifo.size() != 0));
    checkOutput("in_ready", 32'(in_ready), 32'(modelFifo.size() < DEPTH));
    checkOutput("out_valid", 32'(out_valid), 32'(modelOv));
    if (!reset) lastOd = '0;
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_issue", 32'(out_valid), 32'(0));
      end else begin
        logic [DATA_W-1:0] exp;
        exp = expQ.pop_front();
        checkOutput("out_data", out_data, exp);
        lastOd = exp;
      end
    end else begin
      checkOutput("out_data_hold", out_data, lastOd);
    end
  end

  // Two-port round-robin arbiter model: a decision every other cycle, the
  // winner holds grant for a two-cycle window. The other port requests at
  // random.
  int  winLeft = 0;
  bit  lastUs = 1'b0;
  always @(negedge clk) begin
    if (arbOn) begin
      if (winLeft > 0) winLeft--;
      if (winLeft == 0) begin
        bit otherReq;
        otherReq = 1'($urandom_range(0, 1));
        winLeft = 2;
        if (req && (!otherReq || !lastUs)) begin
          arbGrant = 1'b1;
          lastUs = 1'b1;
        end else begin
          arbGrant = 1'b0;
          if (otherReq) lastUs = 1'b0;
        end
      end
    end else begin
      arbGrant = 1'b0;
      winLeft = 0;
    end
  end

  // Offers one transaction and waits (bounded) until the edge that takes it.
  task automatic applyStimulus(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("push_timeout", 32'(n), 32'(0));
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    arbOn = 1'b1;
    while ((modelFifo.size() != 0 || expQ.size() != 0 || modelOv) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", 32'(n), 32'(0));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset held with activity on the inputs.
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    manGrant = 1'b1;
    repeat (3) @(negedge clk);
    in_data = 32'h0000_1234;
    manGrant = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_count", 32'(count), 32'(1));
    drain();

    // Single transaction through the arbiter model.
    applyStimulus(32'hA5A5_0001);
    idle();
    drain();

    // Fill and backpressure.
    arbOn = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(32'h0000_0F00 + 32'(i));
    @(negedge clk);
    in_data = 32'h0000_0FFF;
    repeat (2) @(negedge clk);
    checkOutput("full_in_ready", 32'(in_ready), 32'(0));
    manGrant = 1'b1;
    repeat (2) @(negedge clk);
    manGrant = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("fifth_accepted", 32'(count), 32'(DEPTH));
    drain();

    // Held grant across two windows with three entries buffered.
    arbOn = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'h0000_0B00 + 32'(i));
    idle();
    manGrant = 1'b1;
    repeat (4) @(negedge clk);
    manGrant = 1'b0;
    checkOutput("held_grant_count", 32'(count), 32'(1));
    drain();

    // Wrap and concurrency with the arbiter model.
    arbOn = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(32'(i));
    idle();
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
    end
    idle();
    drain();

    // Reset during the first cycle of a grant window.
    arbOn = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'h0000_0C00 + 32'(i));
    idle();
    manGrant = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    manGrant = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_count", 32'(count), 32'(0));
    arbOn = 1'b1;
    applyStimulus(32'h0000_0007);
    idle();
    drain();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
